demux_class_fifo: RTL and testbench

//   Parametrised 1-to-N class demultiplexer. Steers each input word to output

---
 rtl/demux_class_fifo_if.sv | 31 +++
 rtl/demux_class_fifo.sv | 129 ++++++++++++
 tb/tb_demux_class_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_class_fifo_if.sv
// Bundle between the link input and the per-class queues.
// Ports: in_valid/in_ready/datain_class/class_in/dest carry one word towards a class;
//        out_data/out_valid/out_ready are the N_CLASS queue heads; drop_cnt counts discards.
interface demux_class_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int N_CLASS = 2,
  parameter int CLASS_W = 1,
  parameter int CNT_W   = 8
);
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_W-1:0]                 datain_class;
  logic [CLASS_W-1:0]                class_in;
  logic                              dest;
  logic [N_CLASS*(DATA_W+1)-1:0]     out_data;
  logic [N_CLASS-1:0]                out_valid;
  logic [N_CLASS-1:0]                out_ready;
  logic [CNT_W-1:0]                  drop_cnt;

  // Producer of words and consumer of the queue heads.
  modport master (
    output in_valid, datain_class, class_in, dest, out_ready,
    input  in_ready, out_data, out_valid, drop_cnt
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, datain_class, class_in, dest, out_ready,
    output in_ready, out_data, out_valid, drop_cnt
  );
endinterface

// File: rtl/demux_class_fifo.sv
// 1-to-N class demux: steers each word into a per-class FIFO so one stalled consumer never blocks another.
// Latency: a word accepted at edge k is at its channel head after edge k; no comb path input->output.
// Backpressure: in_ready = !full[class_in] (DROP_ON_FULL=0) or always 1 with drop+count (DROP_ON_FULL=1).
// Ports: clk, reset_L (async, active-low), bus (slave side of demux_class_fifo_if).
module demux_class_fifo #(
  parameter int DATA_W       = 8,
  parameter int N_CLASS      = 2,
  parameter int CLASS_W      = 1,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  demux_class_fifo_if.slave bus
);
  localparam int W    = DATA_W + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int NSEL = 1 << CLASS_W;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]     mem_q    [N_CLASS][DEPTH];
  logic [W-1:0]     mem_d    [N_CLASS][DEPTH];
  logic [AW-1:0]    wr_ptr_q [N_CLASS];
  logic [AW-1:0]    wr_ptr_d [N_CLASS];
  logic [AW-1:0]    rd_ptr_q [N_CLASS];
  logic [AW-1:0]    rd_ptr_d [N_CLASS];
  logic [AW:0]      occ_q    [N_CLASS];
  logic [AW:0]      occ_d    [N_CLASS];
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  logic [NSEL-1:0]    class_ok_mask;
  logic               class_ok;
  logic [N_CLASS-1:0] hit;
  logic [N_CLASS-1:0] full;
  logic [N_CLASS-1:0] push;
  logic [N_CLASS-1:0] pop;
  logic               tgt_full;
  logic               acc;
  logic               drop;

  // Handshake and steering. A constant mask of legal class codes avoids a
  // range compare that is trivially true when 2**CLASS_W == N_CLASS.
  always_comb begin
    class_ok_mask = '0;
    for (int s = 0; s < NSEL; s++) begin
      class_ok_mask[s] = (s < N_CLASS);
    end
    class_ok = class_ok_mask[bus.class_in];

    full = '0;
    hit  = '0;
    pop  = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      full[c] = (occ_q[c] == OCC_FULL);
      hit[c]  = class_ok && (bus.class_in == CLASS_W'(c));
      pop[c]  = (occ_q[c] != '0) && bus.out_ready[c];
    end
    tgt_full = |(hit & full);

    // A full target refuses even if it pops this cycle: ready looks only at
    // occupancy, never at out_ready. Illegal classes are always taken.
    bus.in_ready = (DROP_ON_FULL != 0) || !tgt_full;
    acc          = bus.in_valid && bus.in_ready;
    push         = acc ? (hit & ~full) : '0;
    drop         = acc && (!class_ok || tgt_full);
  end

  // Next-state for storage, pointers, occupancy and the saturating drop counter.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    drop_cnt_d = drop_cnt_q;
    for (int c = 0; c < N_CLASS; c++) begin
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = {bus.dest, bus.datain_class};
        wr_ptr_d[c]           = wr_ptr_q[c] + AW'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
      end
      case ({push[c], pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + (AW+1)'(1);
        2'b01:   occ_d[c] = occ_q[c] - (AW+1)'(1);
        default: occ_d[c] = occ_q[c];
      endcase
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int c = 0; c < N_CLASS; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[c][d] <= '0;
        end
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Heads are driven straight from the registered FIFO state; an empty
  // channel shows zero rather than stale storage.
  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      bus.out_valid[c] = (occ_q[c] != '0);
      if (occ_q[c] != '0) begin
        bus.out_data[c*W +: W] = mem_q[c][rd_ptr_q[c]];
      end
    end
    bus.drop_cnt = drop_cnt_q;
  end
endmodule

// File: tb/tb_demux_class_fifo.sv
// Bench for demux_class_fifo: one backpressure instance (k=0) and one drop-mode instance (k=1),
// each with its own stimulus, checked every cycle against a queue-based model plus literal expectations.
module tb_demux_class_fifo;
  localparam int NC = 4;

  logic clk;
  logic reset_L;

  logic       s_valid [2];
  logic [7:0] s_data  [2];
  logic [2:0] s_class [2];
  logic       s_dest  [2];
  logic [3:0] s_ordy  [2];

  demux_class_fifo_if #(.DATA_W(8), .N_CLASS(NC), .CLASS_W(3), .CNT_W(8)) if_bp ();
  demux_class_fifo_if #(.DATA_W(8), .N_CLASS(NC), .CLASS_W(3), .CNT_W(8)) if_dr ();

  assign if_bp.in_valid     = s_valid[0];
  assign if_bp.datain_class = s_data[0];
  assign if_bp.class_in     = s_class[0];
  assign if_bp.dest         = s_dest[0];
  assign if_bp.out_ready    = s_ordy[0];
  assign if_dr.in_valid     = s_valid[1];
  assign if_dr.datain_class = s_data[1];
  assign if_dr.class_in     = s_class[1];
  assign if_dr.dest         = s_dest[1];
  assign if_dr.out_ready    = s_ordy[1];

  demux_class_fifo #(.DATA_W(8), .N_CLASS(NC), .CLASS_W(3), .DEPTH(4), .DROP_ON_FULL(0), .CNT_W(8))
    u_bp (.clk(clk), .reset_L(reset_L), .bus(if_bp));
  demux_class_fifo #(.DATA_W(8), .N_CLASS(NC), .CLASS_W(3), .DEPTH(4), .DROP_ON_FULL(1), .CNT_W(8))
    u_dr (.clk(clk), .reset_L(reset_L), .bus(if_dr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [8:0] mq [2][NC][$];
  int         mdrop [2];
  int         checks;
  int         failures;

  function automatic bit exp_ready(input int k);
    if (k == 1) return 1'b1;
    if (int'(s_class[k]) >= NC) return 1'b1;
    return mq[k][s_class[k]].size() < 4;
  endfunction

  function automatic logic [35:0] exp_data(input int k);
    logic [35:0] r;
    r = '0;
    for (int c = 0; c < NC; c++)
      if (mq[k][c].size() != 0) r[c*9 +: 9] = mq[k][c][0];
    return r;
  endfunction

  function automatic logic [3:0] exp_valid(input int k);
    logic [3:0] r;
    for (int c = 0; c < NC; c++) r[c] = (mq[k][c].size() != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) mq[k][c].delete();
      mdrop[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    int cls;
    bit pushit, dropit;
    cls    = int'(s_class[k]);
    pushit = 1'b0;
    dropit = 1'b0;
    if (s_valid[k] && exp_ready(k)) begin
      if (cls >= NC || mq[k][cls].size() >= 4) dropit = 1'b1;
      else pushit = 1'b1;
    end
    for (int c = 0; c < NC; c++)
      if (mq[k][c].size() != 0 && s_ordy[k][c]) void'(mq[k][c].pop_front());
    if (pushit) mq[k][cls].push_back({s_dest[k], s_data[k]});
    if (dropit && mdrop[k] < 255) mdrop[k] = mdrop[k] + 1;
  endtask

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("m0_in_ready",  64'(if_bp.in_ready),  64'(exp_ready(0)));
      chk("m0_out_valid", 64'(if_bp.out_valid), 64'(exp_valid(0)));
      chk("m0_out_data",  64'(if_bp.out_data),  64'(exp_data(0)));
      chk("m0_drop_cnt",  64'(if_bp.drop_cnt),  64'(mdrop[0]));
      chk("m1_in_ready",  64'(if_dr.in_ready),  64'(exp_ready(1)));
      chk("m1_out_valid", 64'(if_dr.out_valid), 64'(exp_valid(1)));
      chk("m1_out_data",  64'(if_dr.out_data),  64'(exp_data(1)));
      chk("m1_drop_cnt",  64'(if_dr.drop_cnt),  64'(mdrop[1]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] seq [5];
    checks   = 0;
    failures = 0;
    reset_L  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = 1'b0; s_data[k] = 8'h00; s_class[k] = 3'd0;
      s_dest[k]  = 1'b0; s_ordy[k] = 4'hF;
    end
    seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h12; seq[3] = 8'h13; seq[4] = 8'h14;
    fork
      compare_loop();
    join_none

    // 1. reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bp_valid", 64'(if_bp.out_valid), 64'h0);
    chk("rst_bp_data",  64'(if_bp.out_data),  64'h0);
    chk("rst_bp_drop",  64'(if_bp.drop_cnt),  64'h0);
    chk("rst_bp_ready", 64'(if_bp.in_ready),  64'h1);
    chk("rst_dr_valid", 64'(if_dr.out_valid), 64'h0);
    chk("rst_dr_ready", 64'(if_dr.in_ready),  64'h1);
    @(negedge clk);
    reset_L = 1'b1;
    cyc();

    // 2. routing on the backpressure instance
    s_valid[0] = 1'b1; s_class[0] = 3'd1; s_dest[0] = 1'b0; s_data[0] = 8'h01;
    cyc();
    chk("route_v1",  64'(if_bp.out_valid), 64'b0010);
    chk("route_d1",  64'(if_bp.out_data[9 +: 9]), 64'h001);
    s_class[0] = 3'd2; s_dest[0] = 1'b1; s_data[0] = 8'h03;
    cyc();
    s_valid[0] = 1'b0;
    chk("route_v2",  64'(if_bp.out_valid), 64'b0100);
    chk("route_d2",  64'(if_bp.out_data[18 +: 9]), 64'h103);
    cyc();
    chk("route_empty", 64'(if_bp.out_valid), 64'b0000);

    // 3. backpressure: 10..13 fill channel 0, 14 waits for a pop
    s_ordy[0] = 4'b1110; s_class[0] = 3'd0; s_dest[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid[0] = 1'b1; s_data[0] = seq[i];
      chk("bp_accept_rdy", 64'(if_bp.in_ready), 64'h1);
      cyc();
    end
    s_data[0] = seq[4];
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_rdy", 64'(if_bp.in_ready), 64'h0);
      cyc();
    end
    s_ordy[0] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) s_valid[0] = 1'b0;
      chk("bp_drain_vld",  64'(if_bp.out_valid[0]), 64'h1);
      chk("bp_drain_head", 64'(if_bp.out_data[0 +: 9]), 64'({1'b0, seq[i]}));
      cyc();
    end
    chk("bp_drain_done", 64'(if_bp.out_valid[0]), 64'h0);

    // 4. drop mode: same sequence, 14 is discarded
    s_ordy[1] = 4'b1110; s_class[1] = 3'd0; s_dest[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid[1] = 1'b1; s_data[1] = seq[i];
      chk("dr_rdy", 64'(if_dr.in_ready), 64'h1);
      cyc();
    end
    s_valid[1] = 1'b0;
    chk("dr_cnt1", 64'(if_dr.drop_cnt), 64'h1);
    s_ordy[1] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      chk("dr_drain_head", 64'(if_dr.out_data[0 +: 9]), 64'({1'b0, seq[i]}));
      cyc();
    end
    chk("dr_drain_done", 64'(if_dr.out_valid[0]), 64'h0);
    chk("dr_cnt_hold",   64'(if_dr.drop_cnt), 64'h1);

    // 5. illegal class
    s_valid[0] = 1'b1; s_class[0] = 3'd5; s_data[0] = 8'hAA;
    chk("bad_rdy", 64'(if_bp.in_ready), 64'h1);
    cyc();
    s_valid[0] = 1'b0;
    chk("bad_valid", 64'(if_bp.out_valid), 64'h0);
    chk("bad_cnt",   64'(if_bp.drop_cnt), 64'h1);
    s_valid[0] = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    s_valid[0] = 1'b0;
    chk("bad_sat", 64'(if_bp.drop_cnt), 64'hFF);
    cyc();
    chk("bad_sat_hold", 64'(if_bp.drop_cnt), 64'hFF);

    // 6. mid-operation asynchronous reset
    s_ordy[0] = 4'b0111; s_class[0] = 3'd3; s_dest[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid[0] = 1'b1; s_data[0] = 8'h31 + 8'(i);
      cyc();
    end
    s_valid[0] = 1'b0;
    chk("mr_before", 64'(if_bp.out_valid), 64'b1000);
    #2;
    reset_L = 1'b0;
    #1;
    chk("mr_async_valid", 64'(if_bp.out_valid), 64'h0);
    chk("mr_async_data",  64'(if_bp.out_data),  64'h0);
    chk("mr_async_drop",  64'(if_bp.drop_cnt),  64'h0);
    reset_L = 1'b1;
    cyc();
    chk("mr_after_empty", 64'(if_bp.out_valid), 64'h0);
    s_valid[0] = 1'b1; s_dest[0] = 1'b1; s_data[0] = 8'h44;
    cyc();
    s_valid[0] = 1'b0;
    chk("mr_new_valid", 64'(if_bp.out_valid), 64'b1000);
    chk("mr_new_data",  64'(if_bp.out_data[27 +: 9]), 64'h144);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
